// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared state encoding and default instruction words for the
//               fetch stage; simple_cpu benches may import the word constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

    localparam int unsigned C_INSTR_WIDTH = 20;
    localparam int unsigned C_PC_BITS     = 5;

    localparam logic [C_INSTR_WIDTH-1:0] C_NOP_WORD  = 20'h00000;
    localparam logic [C_INSTR_WIDTH-1:0] C_HALT_WORD = 20'hFFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_prog_mem.sv
// ============================================================================
// Module      : instr_fetch_prog_mem
// Description : Single write port, synchronous read program store.
//               A write to the address being read returns the new word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_prog_mem #(
    parameter int WIDTH = 20,
    parameter int ABITS = 5
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [ABITS-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [ABITS-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(2**ABITS)-1];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch/sequencer feeding simple_cpu: program store,
//               PC, start/stall/abort control and halt sentinel detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                     INSTR_WIDTH = C_INSTR_WIDTH,
    parameter int                     PC_BITS     = C_PC_BITS,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = C_NOP_WORD,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = C_HALT_WORD,
    parameter bit                     LOOP_EN     = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   stall,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc_out,
    output logic                   busy,
    output logic                   done
);

    localparam logic [PC_BITS-1:0] C_PC_LAST = '1;

    fetch_state_t            r_state;
    logic [PC_BITS-1:0]      r_pc;
    logic [INSTR_WIDTH-1:0]  r_instr;
    logic                    r_valid;
    logic [PC_BITS-1:0]      r_pc_out;
    logic                    r_busy;
    logic                    r_done;

    logic [PC_BITS-1:0]      w_pc_next;
    logic [INSTR_WIDTH-1:0]  w_rdata;
    logic                    w_mem_we;
    logic                    w_wrap_end;
    logic                    w_hit_halt;

    // The store is addressed with the next PC so that its registered output
    // always holds mem[r_pc]; this gives the one-edge start-to-issue latency.
    instr_fetch_prog_mem #(
        .WIDTH (INSTR_WIDTH),
        .ABITS (PC_BITS)
    ) u_prog_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (w_pc_next),
        .o_rdata (w_rdata)
    );

    assign w_mem_we   = prog_we && (r_state != S_RUN);
    assign w_hit_halt = (w_rdata == HALT_WORD);
    // Last word of the store has just been issued and wrapping is disabled.
    assign w_wrap_end = !LOOP_EN && r_valid && (r_pc_out == C_PC_LAST);

    always_comb begin
        w_pc_next = r_pc;
        case (r_state)
            S_IDLE: begin
                w_pc_next = '0;
            end
            S_RUN: begin
                if (abort) begin
                    w_pc_next = '0;
                end else if (!stall && !w_wrap_end && !w_hit_halt) begin
                    w_pc_next = r_pc + 1'b1;
                end
            end
            S_HALT: begin
                if (abort || start) begin
                    w_pc_next = '0;
                end
            end
            default: begin
                w_pc_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_instr  <= NOP_WORD;
            r_valid  <= 1'b0;
            r_pc_out <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            case (r_state)
                S_IDLE: begin
                    if (!abort && start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        r_instr  <= NOP_WORD;
                        r_valid  <= 1'b0;
                        r_pc_out <= '0;
                        r_busy   <= 1'b0;
                    end else if (stall) begin
                        r_state <= S_RUN;
                    end else if (w_wrap_end || w_hit_halt) begin
                        r_state <= S_HALT;
                        r_instr <= NOP_WORD;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_instr  <= w_rdata;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end else if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_instr  <= NOP_WORD;
                    r_valid  <= 1'b0;
                    r_pc_out <= '0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign pc_out      = r_pc_out;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch, both wrap modes side by
//               side against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam int          IW    = 20;
    localparam int          PB    = 5;
    localparam int          DEPTH = 32;
    localparam logic [IW-1:0] HALTW = 20'hFFFFF;
    localparam logic [IW-1:0] NOPW  = 20'h00000;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          prog_we   = 1'b0;
    logic [PB-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          stall     = 1'b0;

    logic [1:0][IW-1:0] instr_o;
    logic [1:0][PB-1:0] pc_o;
    logic [1:0]         valid_o;
    logic [1:0]         busy_o;
    logic [1:0]         done_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model, index 0 = no wrap, index 1 = wrap
    logic [IW-1:0] m_mem   [2][DEPTH];
    int            m_mode  [2];        // 0 idle, 1 run, 2 halt
    int            m_pc    [2];
    bit            m_last  [2];
    logic [IW-1:0] m_out   [2];
    bit            m_valid [2];
    int            m_pcout [2];
    bit            m_done  [2];

    always #5 clk = ~clk;

    instr_fetch #(.LOOP_EN(1'b0)) u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .abort       (abort),
        .stall       (stall),
        .instr_out   (instr_o[0]),
        .instr_valid (valid_o[0]),
        .pc_out      (pc_o[0]),
        .busy        (busy_o[0]),
        .done        (done_o[0])
    );

    instr_fetch #(.LOOP_EN(1'b1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .abort       (abort),
        .stall       (stall),
        .instr_out   (instr_o[1]),
        .instr_valid (valid_o[1]),
        .pc_out      (pc_o[1]),
        .busy        (busy_o[1]),
        .done        (done_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k]  = 0;
            m_pc[k]    = 0;
            m_last[k]  = 1'b0;
            m_out[k]   = NOPW;
            m_valid[k] = 1'b0;
            m_pcout[k] = 0;
            m_done[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int pre_mode;
            pre_mode = m_mode[k];
            case (m_mode[k])
                0: begin
                    if (!abort && start) begin
                        m_mode[k] = 1;
                        m_pc[k]   = 0;
                        m_last[k] = 1'b0;
                    end
                end
                1: begin
                    if (abort) begin
                        m_mode[k]  = 0;
                        m_out[k]   = NOPW;
                        m_valid[k] = 1'b0;
                        m_pc[k]    = 0;
                        m_last[k]  = 1'b0;
                    end else if (!stall) begin
                        if (m_last[k] || m_mem[k][m_pc[k]] == HALTW) begin
                            m_mode[k]  = 2;
                            m_out[k]   = NOPW;
                            m_valid[k] = 1'b0;
                            m_done[k]  = 1'b1;
                            m_last[k]  = 1'b0;
                        end else begin
                            m_out[k]   = m_mem[k][m_pc[k]];
                            m_valid[k] = 1'b1;
                            m_pcout[k] = m_pc[k];
                            if (m_pc[k] == DEPTH - 1 && k == 0) m_last[k] = 1'b1;
                            m_pc[k] = (m_pc[k] + 1) % DEPTH;
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        m_mode[k] = 0;
                        m_done[k] = 1'b0;
                    end else if (start) begin
                        m_mode[k] = 1;
                        m_pc[k]   = 0;
                        m_done[k] = 1'b0;
                        m_last[k] = 1'b0;
                    end
                end
            endcase
            if (prog_we && pre_mode != 1) m_mem[k][prog_addr] = prog_data;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d.instr_out", k), 32'(instr_o[k]), 32'(m_out[k]));
            chk($sformatf("d%0d.instr_valid", k), 32'(valid_o[k]), 32'(m_valid[k]));
            chk($sformatf("d%0d.busy", k), 32'(busy_o[k]), 32'(m_mode[k] == 1));
            chk($sformatf("d%0d.done", k), 32'(done_o[k]), 32'(m_done[k]));
            if (m_valid[k]) chk($sformatf("d%0d.pc_out", k), 32'(pc_o[k]), 32'(m_pcout[k]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check_all();
    endtask

    task automatic load(input int a, input logic [IW-1:0] d);
        prog_addr = PB'(a);
        prog_data = d;
        prog_we   = 1'b1;
        cyc();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Reset pulse placed between clock edges; outputs must react before the next edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        for (int k = 0; k < 2; k++) chk($sformatf("d%0d.pc_out_rst", k), 32'(pc_o[k]), 32'd0);
        #1 rst = 1'b0;
    endtask

    task automatic load_basic();
        load(0, 20'h00001);
        load(1, 20'h00002);
        load(2, 20'h00003);
        load(3, HALTW);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < DEPTH; a++) m_mem[k][a] = NOPW;
        model_reset();

        #1 rst = 1'b1;
        #1;
        check_all();
        for (int k = 0; k < 2; k++) chk($sformatf("d%0d.pc_out_rst", k), 32'(pc_o[k]), 32'd0);
        cyc();
        cyc();
        @(negedge clk);
        rst = 1'b0;

        // Basic run to the halt sentinel
        load_basic();
        pulse_start();
        repeat (6) cyc();

        // Stall while the second word is on the output
        pulse_start();
        cyc();
        cyc();
        stall = 1'b1;
        cyc();
        cyc();
        stall = 1'b0;
        repeat (4) cyc();

        // Abort mid-run, then restart from address 0
        pulse_start();
        cyc();
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        repeat (2) cyc();
        pulse_start();
        repeat (5) cyc();

        // Full store, no sentinel: halt on wrap vs. continuous loop
        for (int a = 0; a < DEPTH; a++) load(a, IW'(a));
        pulse_start();
        repeat (36) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();

        // Writes during a run are ignored
        load(0, 20'h00011);
        load(1, 20'h00022);
        load(2, 20'h00033);
        load(3, 20'h00044);
        load(4, HALTW);
        pulse_start();
        prog_addr = 5'd2;
        prog_data = 20'h0ABCD;
        prog_we   = 1'b1;
        cyc();
        prog_we   = 1'b0;
        repeat (6) cyc();

        // Asynchronous reset mid-run; program survives
        pulse_start();
        cyc();
        cyc();
        async_reset();
        cyc();
        pulse_start();
        repeat (7) cyc();

        // Random phase
        for (int a = 0; a < DEPTH; a++)
            load(a, ($urandom_range(0, 15) == 0) ? HALTW : IW'($urandom));
        for (int i = 0; i < 3000; i++) begin
            prog_we   = ($urandom_range(0, 9) < 2);
            prog_addr = PB'($urandom_range(0, DEPTH - 1));
            prog_data = ($urandom_range(0, 19) == 0) ? HALTW : IW'($urandom);
            start     = ($urandom_range(0, 9) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            stall     = ($urandom_range(0, 4) == 0);
            cyc();
            if ($urandom_range(0, 299) == 0) async_reset();
        end
        prog_we = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        stall   = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
